// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the RV32IM pipeline stall controller and its hazard detector.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN         = 1'b0,
        MULDIV_WAIT = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detection between the stage-3 load and the stage-2 reader.
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_addr,
    input  logic [REG_ADDR_W-1:0] id_addr1,
    input  logic [REG_ADDR_W-1:0] id_addr2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    output logic                  hazard
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = id_uses_rs1 && (ex_addr == id_addr1);
        rs2_hit = id_uses_rs2 && (ex_addr == id_addr2);
        // x0 is never written, so a load targeting it cannot create a dependency
        hazard  = ex_mem_read && (ex_addr != REG_ZERO) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage RV32IM core: load-use, multi-cycle mul/div
// with watchdog, stage-3 taken branches, plus a saturating stall-cycle counter.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_TIMEOUT = 40,
    parameter int CNT_W          = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [REG_ADDR_W-1:0] ID_ADDR1,
    input  logic [REG_ADDR_W-1:0] ID_ADDR2,
    input  logic                  ID_USES_RS1,
    input  logic                  ID_USES_RS2,
    input  logic [REG_ADDR_W-1:0] EX_ADDR,
    input  logic                  EX_MEM_READ,
    input  logic                  EX_MULDIV,
    input  logic                  MULDIV_DONE,
    input  logic                  BRANCH_TAKEN,
    output logic                  PC_WRITE_EN,
    output logic                  IF_ID_WRITE_EN,
    output logic                  ID_EX_WRITE_EN,
    output logic                  IF_ID_FLUSH,
    output logic                  ID_EX_BUBBLE,
    output logic                  EX_MEM_BUBBLE,
    output logic                  MULDIV_START,
    output logic                  MULDIV_ERROR,
    output logic [CNT_W-1:0]      STALL_COUNT
);

    localparam int WD_W = (MULDIV_TIMEOUT > 1) ? $clog2(MULDIV_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MULDIV_TIMEOUT - 1);

    ctrl_state_e      state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    load_use_detector u_load_use (
        .ex_mem_read (EX_MEM_READ),
        .ex_addr     (EX_ADDR),
        .id_addr1    (ID_ADDR1),
        .id_addr2    (ID_ADDR2),
        .id_uses_rs1 (ID_USES_RS1),
        .id_uses_rs2 (ID_USES_RS2),
        .hazard      (load_use)
    );

    always_comb begin
        state_d        = state_q;
        wd_d           = wd_q;
        err_d          = err_q;
        PC_WRITE_EN    = 1'b1;
        IF_ID_WRITE_EN = 1'b1;
        ID_EX_WRITE_EN = 1'b1;
        IF_ID_FLUSH    = 1'b0;
        ID_EX_BUBBLE   = 1'b0;
        EX_MEM_BUBBLE  = 1'b0;
        MULDIV_START   = 1'b0;

        if (RESET) begin
            PC_WRITE_EN    = 1'b0;
            IF_ID_WRITE_EN = 1'b0;
            ID_EX_WRITE_EN = 1'b0;
            IF_ID_FLUSH    = 1'b1;
            ID_EX_BUBBLE   = 1'b1;
            EX_MEM_BUBBLE  = 1'b1;
            state_d        = RUN;
            wd_d           = '0;
        end else begin
            case (state_q)
                RUN: begin
                    // A taken branch outranks a simultaneous mul/div: that op is on the wrong path
                    if (BRANCH_TAKEN) begin
                        IF_ID_FLUSH  = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                    end else if (EX_MULDIV) begin
                        MULDIV_START = 1'b1;
                        if (!MULDIV_DONE) begin
                            PC_WRITE_EN    = 1'b0;
                            IF_ID_WRITE_EN = 1'b0;
                            ID_EX_WRITE_EN = 1'b0;
                            EX_MEM_BUBBLE  = 1'b1;
                            state_d        = MULDIV_WAIT;
                            wd_d           = '0;
                        end
                    end else if (load_use) begin
                        PC_WRITE_EN    = 1'b0;
                        IF_ID_WRITE_EN = 1'b0;
                        ID_EX_BUBBLE   = 1'b1;
                    end
                end
                MULDIV_WAIT: begin
                    if (MULDIV_DONE) begin
                        state_d = RUN;
                    end else if (wd_q == WD_LAST) begin
                        state_d = RUN;
                        err_d   = 1'b1;
                    end else begin
                        PC_WRITE_EN    = 1'b0;
                        IF_ID_WRITE_EN = 1'b0;
                        ID_EX_WRITE_EN = 1'b0;
                        EX_MEM_BUBBLE  = 1'b1;
                        wd_d           = wd_q + WD_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end

        cnt_d = cnt_q;
        if (!PC_WRITE_EN && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= RUN;
            wd_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign MULDIV_ERROR = err_q;
    assign STALL_COUNT  = cnt_q;

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Sequences pipeline-register enables, bubbles and flushes for the 5-stage RV32IM core. It sits alongside the stage-3 forwarding unit. It resolves the three hazards forwarding cannot cover:
- load-use (one-cycle stall),
- multi-cycle M-extension operations (freeze until the mul/div unit completes, with a watchdog),
- taken branches/jumps resolved in stage 3 (squash stages 1–2).

It also keeps a saturating stall-cycle counter for performance analysis.

## Interface
Clock `CLK`; reset `RESET`, asynchronous, active-high.

Parameters:
- `MULDIV_TIMEOUT`, 40: maximum `MULDIV_WAIT` cycles before abort.
- `CNT_W`, 32: width of `STALL_COUNT`.

Ports:
- `CLK` in 1: core clock.
- `RESET` in 1: async active-high reset.
- `ID_ADDR1`, `ID_ADDR2` in 5: rs1/rs2 of the stage-2 instruction.
- `ID_USES_RS1`, `ID_USES_RS2` in 1: stage-2 instruction reads rs1/rs2.
- `EX_ADDR` in 5: rd of the stage-3 instruction.
- `EX_MEM_READ` in 1: stage-3 instruction is a load.
- `EX_MULDIV` in 1: stage-3 instruction is a multi-cycle M-extension op.
- `MULDIV_DONE` in 1: mul/div result valid this cycle.
- `BRANCH_TAKEN` in 1: stage-3 branch/jump resolved taken.
- `PC_WRITE_EN`, `IF_ID_WRITE_EN`, `ID_EX_WRITE_EN` out 1: register load enables.
- `IF_ID_FLUSH` out 1: load a NOP into IF/ID.
- `ID_EX_BUBBLE` out 1: load a NOP into ID/EX.
- `EX_MEM_BUBBLE` out 1: load a NOP into EX/MEM.
- `MULDIV_START` out 1: one-cycle start pulse to the mul/div unit.
- `MULDIV_ERROR` out 1: sticky watchdog flag.
- `STALL_COUNT` out `CNT_W`: cycles with `PC_WRITE_EN`=0.

## Operation
- States: `RUN`, `MULDIV_WAIT`. Control outputs are Mealy (state + inputs). `STALL_COUNT` and `MULDIV_ERROR` are registered.
- `RUN` default: all enables 1, all flush/bubble 0, `MULDIV_START` 0.
- `RUN` priority, highest first:
  - `BRANCH_TAKEN`: `IF_ID_FLUSH`=1, `ID_EX_BUBBLE`=1, enables 1; stay in `RUN`.
  - `EX_MULDIV`: `MULDIV_START`=1.
    - If `MULDIV_DONE` is also 1: no stall; stay in `RUN`.
    - Otherwise: `PC`/`IF_ID`/`ID_EX` enables 0, `EX_MEM_BUBBLE`=1; go to `MULDIV_WAIT`; clear the watchdog count.
  - Load-use: `EX_MEM_READ` and `EX_ADDR`≠0 and ((`ID_USES_RS1` and `EX_ADDR`==`ID_ADDR1`) or (`ID_USES_RS2` and `EX_ADDR`==`ID_ADDR2`)).
    - Response: `PC_WRITE_EN`=`IF_ID_WRITE_EN`=0, `ID_EX_BUBBLE`=1.
    - Stay in `RUN`. Next cycle the load is in stage 4 and forwarding takes over.
- `MULDIV_WAIT`:
  - Freeze: the three enables 0, `EX_MEM_BUBBLE`=1, `MULDIV_START` 0.
  - Load-use and branch inputs are ignored.
  - `MULDIV_DONE`=1: release (all enables 1, `EX_MEM_BUBBLE`=0) in that same cycle; go to `RUN`.
  - Watchdog count reaches `MULDIV_TIMEOUT`-1 without `MULDIV_DONE`: release as above; set `MULDIV_ERROR`; go to `RUN`.
- `BRANCH_TAKEN` and `EX_MULDIV` both 1 is illegal; the branch wins.
- `STALL_COUNT` increments in every post-reset cycle with `PC_WRITE_EN`=0 and saturates at all-ones.
- `MULDIV_ERROR` stays set until reset.

## Timing
- While `RESET`=1:
  - state `RUN`;
  - all enables 0, `IF_ID_FLUSH`=`ID_EX_BUBBLE`=`EX_MEM_BUBBLE`=1;
  - `MULDIV_START` 0, `MULDIV_ERROR` 0, `STALL_COUNT` 0, watchdog count 0.
- Reset mid-`MULDIV_WAIT` abandons the operation. After release the controller is in `RUN` with default outputs.
- Latency:
  - Load-use costs exactly 1 bubble.
  - A mul/div with DONE k cycles after START (k≥1) costs k stall cycles.
  - A branch costs 2 squashed instructions, 0 stall cycles.
- `MULDIV_START` is asserted in exactly one cycle per mul/div instruction, never in `MULDIV_WAIT`.
- The watchdog counts from 0 in the first `MULDIV_WAIT` cycle, so the timeout occurs after `MULDIV_TIMEOUT` wait cycles.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - state encoding (`RUN`=1'b0, `MULDIV_WAIT`=1'b1);
  - `REG_ZERO`=5'd0;
  - `REG_ADDR_W`=5.
- Sub-module `load_use_detector`: the purely combinational comparator that produces the load-use hazard bit.
- FSM, watchdog and counter stay in the top module.

## Test plan
- Load x5 in stage 3 (`EX_MEM_READ`=1, `EX_ADDR`=5), stage 2 reads rs2=5 → one cycle with `PC_WRITE_EN`=0, `ID_EX_BUBBLE`=1; next cycle all enables 1; `STALL_COUNT` +1.
- Load to x0 with stage-2 rs1=0; also load x5 with `ID_USES_RS1`=0 and `ID_ADDR1`=5 → no stall in either case.
- `EX_MULDIV`=1, `MULDIV_DONE` 4 cycles after START → START pulses once; 4 freeze cycles with `EX_MEM_BUBBLE`=1; release in the DONE cycle; `STALL_COUNT`=4.
- `EX_MULDIV`=1 with `MULDIV_DONE`=1 in the same cycle → `MULDIV_START`=1, no stall, stays in `RUN`.
- `MULDIV_DONE` never arrives, `MULDIV_TIMEOUT`=40 → release after 40 wait cycles; `MULDIV_ERROR`=1 and held; `RESET` pulse clears it and `STALL_COUNT`.
- `BRANCH_TAKEN`=1 together with a load-use match → `IF_ID_FLUSH`=`ID_EX_BUBBLE`=1, `PC_WRITE_EN`=1, no stall counted.
